// File: rtl/sha256_nonce_block_if.sv
// Bus bundle for sha256_nonce_block: sweep control, captured inputs and hash results.
// With SHA256_NONCE_BASE_EN defined the bundle also carries nonce_base.
interface sha256_nonce_block_if;
  logic                      start;
  logic [7:0][31:0]          midstate;
  logic [2:0][31:0]          tail;
  logic                      done;
  logic [15:0][7:0][31:0]    hout;
`ifdef SHA256_NONCE_BASE_EN
  logic [31:0]               nonce_base;
`endif

  modport master (
    output start,
    output midstate,
    output tail,
`ifdef SHA256_NONCE_BASE_EN
    output nonce_base,
`endif
    input  done,
    input  hout
  );

  modport slave (
    input  start,
    input  midstate,
    input  tail,
`ifdef SHA256_NONCE_BASE_EN
    input  nonce_base,
`endif
    output done,
    output hout
  );
endinterface

// File: rtl/sha256_nonce_block.sv
// Phase-2 bitcoin hash stage: second header block per nonce, one SHA-256 round per cycle.
// Optional macro SHA256_NONCE_BASE_EN adds a captured nonce_base offset to header word 3.
module sha256_nonce_block #(
  parameter int unsigned NUM_NONCES = 16
) (
  input logic                 clk,
  input logic                 reset,
  sha256_nonce_block_if.slave bus
);

  localparam int unsigned LAST = NUM_NONCES - 1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t           state;
  logic [3:0]       n;
  logic [5:0]       t;
  logic [7:0][31:0] mid_q;
  logic [2:0][31:0] tail_q;
  logic [7:0][31:0] st;      // working registers a..h at index 0..7
  logic [15:0][31:0] w;      // w[0] is W[t]; w[15] is W[t+15]
  logic [31:0]      t1, t2, w_new, w3;
`ifdef SHA256_NONCE_BASE_EN
  logic [31:0]      base_q;
`endif

  always_comb begin
    t1    = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[t] + w[0];
    t2    = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
    w_new = w[0] + ssig0(w[1]) + w[9] + ssig1(w[14]);
`ifdef SHA256_NONCE_BASE_EN
    w3    = base_q + 32'(n);
`else
    w3    = 32'(n);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bus.done <= 1'b1;
      bus.hout <= '0;
      n        <= '0;
      t        <= '0;
      mid_q    <= '0;
      tail_q   <= '0;
      st       <= '0;
      w        <= '0;
`ifdef SHA256_NONCE_BASE_EN
      base_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mid_q    <= bus.midstate;
            tail_q   <= bus.tail;
`ifdef SHA256_NONCE_BASE_EN
            base_q   <= bus.nonce_base;
`endif
            n        <= '0;
            bus.done <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          st    <= mid_q;
          w     <= {32'd640, {10{32'h0}}, 32'h8000_0000, w3, tail_q};
          t     <= '0;
          state <= ROUND;
        end
        ROUND: begin
          st[0] <= t1 + t2;
          st[1] <= st[0];
          st[2] <= st[1];
          st[3] <= st[2];
          st[4] <= st[3] + t1;
          st[5] <= st[4];
          st[6] <= st[5];
          st[7] <= st[6];
          w     <= {w_new, w[15:1]};
          t     <= t + 6'd1;
          if (t == 6'd63) state <= FINAL;
        end
        FINAL: begin
          for (int j = 0; j < 8; j++) bus.hout[n][j] <= mid_q[j] + st[j];
          if (n == 4'(LAST)) begin
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            n     <= n + 4'd1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_block.sv
// Directed bench for sha256_nonce_block: a 16-nonce and a 1-nonce instance against a
// full-schedule software SHA-256 compression model.
module tb_sha256_nonce_block;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_nonce_block_if bus16 ();
  sha256_nonce_block_if bus1 ();

  sha256_nonce_block #(.NUM_NONCES(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
  sha256_nonce_block #(.NUM_NONCES(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] KK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // index 0 is H0
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [7:0][31:0] ABC_DIGEST = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };
  localparam logic [2:0][31:0] TAIL_Z = '0;
  localparam logic [2:0][31:0] TAIL_B = {32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] iv, input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2, s0, s1;
    logic [7:0][31:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3]; e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int i = 0; i < 64; i++) begin
      x1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KK[i] + w[i];
      x2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    r[0] = iv[0] + a; r[1] = iv[1] + b; r[2] = iv[2] + c; r[3] = iv[3] + d;
    r[4] = iv[4] + e; r[5] = iv[5] + f; r[6] = iv[6] + g; r[7] = iv[7] + h;
    return r;
  endfunction

  function automatic logic [15:0][31:0] mk_blk(input logic [2:0][31:0] tl, input logic [31:0] w3);
    logic [15:0][31:0] b;
    b = '0;
    b[0] = tl[0]; b[1] = tl[1]; b[2] = tl[2]; b[3] = w3;
    b[4] = 32'h8000_0000; b[15] = 32'd640;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_nz(input logic [15:0][7:0][31:0] hv, input int from, output int nz);
    nz = 0;
    for (int i = from; i < 16; i++)
      for (int j = 0; j < 8; j++)
        if (hv[i][j] != 32'h0) nz++;
  endtask

  task automatic verify(input string pfx, input logic [15:0][7:0][31:0] hv, input int cnt,
                        input logic [7:0][31:0] ms, input logic [2:0][31:0] tl, input logic [31:0] base);
    logic [7:0][31:0] e;
    for (int i = 0; i < cnt; i++) begin
      e = compress(ms, mk_blk(tl, base + 32'(i)));
      for (int j = 0; j < 8; j++) check($sformatf("%s_h%0d_%0d", pfx, i, j), hv[i][j], e[j]);
    end
  endtask

  task automatic run16(input string pfx, input logic [7:0][31:0] ms, input logic [2:0][31:0] tl,
                       input logic [31:0] base, input bit poke);
    int cyc;
    bus16.midstate = ms;
    bus16.tail     = tl;
`ifdef SHA256_NONCE_BASE_EN
    bus16.nonce_base = base;
`endif
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check({pfx, "_done_fall"}, 32'(bus16.done), 32'd0);
    cyc = 0;
    while (!bus16.done && cyc < 3000) begin
      tick();
      cyc++;
      if (poke && cyc == 5) begin
        bus16.midstate = '1;
        bus16.tail     = '1;
      end
    end
    check({pfx, "_cycles"}, 32'(cyc), 32'd1056);
  endtask

  initial begin
    int nz;
    int cyc;
    logic [7:0][31:0]  dg;
    logic [15:0][31:0] abc;

    bus16.start = 1'b0; bus16.midstate = '0; bus16.tail = '0;
    bus1.start  = 1'b0; bus1.midstate  = '0; bus1.tail  = '0;
`ifdef SHA256_NONCE_BASE_EN
    bus16.nonce_base = '0;
    bus1.nonce_base  = '0;
`endif

    // reference model sanity: SHA-256("abc")
    abc = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    dg = compress(IV, abc);
    for (int j = 0; j < 8; j++) check($sformatf("model_abc_%0d", j), dg[j], ABC_DIGEST[j]);

    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_done16", 32'(bus16.done), 32'd1);
    check("rst_done1", 32'(bus1.done), 32'd1);
    count_nz(bus16.hout, 0, nz);
    check("rst_nz16", 32'(nz), 32'd0);
    count_nz(bus1.hout, 0, nz);
    check("rst_nz1", 32'(nz), 32'd0);

    run16("iv", IV, TAIL_Z, 32'h0, 1'b0);
    verify("iv", bus16.hout, 16, IV, TAIL_Z, 32'h0);

    run16("iso", IV, TAIL_B, 32'h0, 1'b1);
    verify("iso", bus16.hout, 16, IV, TAIL_B, 32'h0);
    check("iso_h3_ne_h2", 32'(bus16.hout[3] != bus16.hout[2]), 32'd1);

    // abort a sweep with reset at cycle 500
    bus16.midstate = IV;
    bus16.tail     = TAIL_Z;
    bus16.start    = 1'b1;
    tick();
    bus16.start = 1'b0;
    repeat (499) tick();
    check("abort_busy", 32'(bus16.done), 32'd0);
    reset = 1'b1;
    tick();
    check("abort_done", 32'(bus16.done), 32'd1);
    count_nz(bus16.hout, 0, nz);
    check("abort_nz", 32'(nz), 32'd0);
    reset = 1'b0;
    tick();
    run16("fresh", IV, TAIL_B, 32'h0, 1'b0);
    verify("fresh", bus16.hout, 16, IV, TAIL_B, 32'h0);

    // single-nonce instance; a start pulse mid-sweep must be ignored
    bus1.midstate = IV;
    bus1.tail     = TAIL_B;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("n1_done_fall", 32'(bus1.done), 32'd0);
    cyc = 0;
    while (!bus1.done && cyc < 500) begin
      tick();
      cyc++;
      bus1.start = (cyc == 20);
    end
    bus1.start = 1'b0;
    check("n1_cycles", 32'(cyc), 32'd66);
    verify("n1", bus1.hout, 1, IV, TAIL_B, 32'h0);
    count_nz(bus1.hout, 1, nz);
    check("n1_upper_nz", 32'(nz), 32'd0);
    tick();
    check("n1_stays_idle", 32'(bus1.done), 32'd1);

`ifdef SHA256_NONCE_BASE_EN
    run16("base", IV, TAIL_B, 32'hFFFF_FFFF, 1'b0);
    verify("base", bus16.hout, 16, IV, TAIL_B, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
